// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source with a valid/ready load port and gapless back-to-back frames.
// Optional build macro PARITY_EN appends one even-parity bit to every frame.
module serial_bit_source #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_load_valid,
   output logic             o_load_ready,
   output logic             o_sequence,
   output logic             o_seq_valid,
   output logic             o_frame_done
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
`ifdef PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT
`ifdef PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic             r_seq;
   logic             r_valid;
   logic             r_done;
`ifdef PARITY_EN
   logic             r_par;
`endif

   logic             w_data_last;
   logic             w_last;
   logic             w_accept;
   logic             w_first_bit;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_load_shift;
   logic [WIDTH-1:0] w_step_shift;

   // The bit on the output now is the last one of the data portion
   assign w_data_last = (r_state == S_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

`ifdef PARITY_EN
   assign w_last = (r_state == S_PARITY);
`else
   assign w_last = w_data_last;
`endif

   // Ready in IDLE or on the frame's final cycle so the next word follows with no gap
   assign o_load_ready = i_rst && ((r_state == S_IDLE) || w_last);
   assign w_accept     = i_load_valid && o_load_ready;

   // Shift register holds the bits not yet presented, next one at the outgoing end
   assign w_first_bit  = MSB_FIRST ? i_load_data[WIDTH-1] : i_load_data[0];
   assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1]     : r_shift[0];
   assign w_load_shift = MSB_FIRST ? (i_load_data << 1)   : (i_load_data >> 1);
   assign w_step_shift = MSB_FIRST ? (r_shift << 1)       : (r_shift >> 1);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
         r_seq   <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
`ifdef PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state <= S_SHIFT;
         r_cnt   <= '0;
         r_shift <= w_load_shift;
         r_seq   <= w_first_bit;
         r_valid <= 1'b1;
         r_done  <= 1'b0;
`ifdef PARITY_EN
         r_par   <= ^i_load_data;
`endif
      end else begin
         case (r_state)
            S_SHIFT: begin
               if (w_data_last) begin
`ifdef PARITY_EN
                  r_state <= S_PARITY;
                  r_seq   <= r_par;
                  r_valid <= 1'b1;
                  r_done  <= 1'b1;
`else
                  r_state <= S_IDLE;
                  r_seq   <= 1'b0;
                  r_valid <= 1'b0;
                  r_done  <= 1'b0;
`endif
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_shift <= w_step_shift;
                  r_seq   <= w_next_bit;
                  r_valid <= 1'b1;
                  // Pulse lands on the last data bit only when no parity bit follows
                  r_done  <= !PAR_EN && (r_cnt == CNT_W'(WIDTH - 2));
               end
            end
`ifdef PARITY_EN
            S_PARITY: begin
               r_state <= S_IDLE;
               r_seq   <= 1'b0;
               r_valid <= 1'b0;
               r_done  <= 1'b0;
            end
`endif
            default: begin
               r_state <= S_IDLE;
               r_seq   <= 1'b0;
               r_valid <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_sequence   = r_seq;
   assign o_seq_valid  = r_valid;
   assign o_frame_done = r_done;

endmodule
